shift_add_mult: RTL and testbench

Iterative radix-2 shift-and-add unsigned multiplier for the multiplier datapath. Consumes one operand pair per start handshake, retires one multiplier bit per clock, and presents a registered 2·WIDTH-bit product with a single-cycle done pulse. It sits directly downstream of the LUT-based partial-product logic. The per-cycle conditional add maps onto LUT4/LUT5 fabric cells. The sequencing and accumulation registers live here.

---
 rtl/shift_add_mult_pkg.sv | 21 ++
 rtl/shift_add_mult_if.sv | 24 ++
 rtl/mult_add_row.sv | 19 +
 rtl/shift_add_mult.sv | 93 +++++++++
 tb/tb_shift_add_mult.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/shift_add_mult_pkg.sv
// Shared definitions for the iterative shift-and-add multiplier:
// state encoding and the counter-width helper.
package shift_add_mult_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Number of bits needed to count 0..value-1; bounded loop keeps it elaboration-friendly.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/shift_add_mult_if.sv
// Start/result handshake bundle between a requester and the multiplier.
interface shift_add_mult_if #(
  parameter int WIDTH = 8
);

  logic                   start;
  logic [WIDTH-1:0]       a;
  logic [WIDTH-1:0]       b;
  logic                   ready;
  logic                   busy;
  logic                   done;
  logic [2*WIDTH-1:0]     product;

  modport master (
    output start, a, b,
    input  ready, busy, done, product
  );

  modport slave (
    input  start, a, b,
    output ready, busy, done, product
  );

endinterface

// File: rtl/mult_add_row.sv
// Combinational (WIDTH+1)-bit conditional adder: adds the multiplicand to the
// running high word only when the current multiplier bit is set.
module mult_add_row #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   hi,
  input  logic [WIDTH-1:0] mcand,
  input  logic             sel,
  output logic [WIDTH:0]   sum
);

  logic [WIDTH:0] addend;

  always_comb begin
    addend = sel ? {1'b0, mcand} : '0;
    sum    = hi + addend;
  end

endmodule

// File: rtl/shift_add_mult.sv
// Radix-2 shift-and-add unsigned multiplier: one multiplier bit per clock,
// fixed WIDTH-cycle run, registered product with a one-cycle done pulse.
module shift_add_mult
  import shift_add_mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  shift_add_mult_if.slave  bus
);

  localparam int CNT_W = clog2(WIDTH);

  state_t               state;
  state_t               state_next;
  logic [WIDTH-1:0]     mcand;
  logic [WIDTH:0]       hi;
  logic [WIDTH-1:0]     lo;
  logic [WIDTH:0]       sum;
  logic [CNT_W-1:0]     cnt;
  logic [2*WIDTH-1:0]   product_q;
  logic                 last;

  assign last = (cnt == CNT_W'(WIDTH - 1));

  mult_add_row #(
    .WIDTH (WIDTH)
  ) u_add_row (
    .hi    (hi),
    .mcand (mcand),
    .sel   (lo[0]),
    .sum   (sum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = ST_IDLE;
    case (state)
      ST_IDLE: state_next = bus.start ? ST_RUN : ST_IDLE;
      ST_RUN:  state_next = last ? ST_DONE : ST_RUN;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // The unused code 2'd3 falls into the default arm and looks like IDLE.
  always_comb begin
    bus.ready = 1'b0;
    bus.busy  = 1'b0;
    bus.done  = 1'b0;
    case (state)
      ST_RUN:  bus.busy  = 1'b1;
      ST_DONE: bus.done  = 1'b1;
      default: bus.ready = 1'b1;
    endcase
  end

  // The final product is the post-shift {hi,lo} with the always-zero guard bit dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand     <= '0;
      hi        <= '0;
      lo        <= '0;
      cnt       <= '0;
      product_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            mcand <= bus.a;
            hi    <= '0;
            lo    <= bus.b;
            cnt   <= '0;
          end
        end
        ST_RUN: begin
          {hi, lo} <= {1'b0, sum, lo[WIDTH-1:1]};
          cnt      <= cnt + 1'b1;
          if (last) product_q <= {sum, lo[WIDTH-1:1]};
        end
        default: ;
      endcase
    end
  end

  assign bus.product = product_q;

endmodule

// File: tb/tb_shift_add_mult.sv
// Directed self-checking bench for shift_add_mult at WIDTH=8 and WIDTH=32.
module tb_shift_add_mult;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  shift_add_mult_if #(.WIDTH(8))  bus8 ();
  shift_add_mult_if #(.WIDTH(32)) bus32 ();

  shift_add_mult #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  shift_add_mult #(.WIDTH(32)) dut32 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Launches one 8-bit operation from a negedge and returns at the negedge where done is seen.
  task automatic run_op8(input logic [7:0] op_a, input logic [7:0] op_b,
                         output int done_at, output int busy_cnt);
    bus8.a     = op_a;
    bus8.b     = op_b;
    bus8.start = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    bus8.a     = 8'hA5;
    bus8.b     = 8'h5A;
    done_at    = 0;
    busy_cnt   = 0;
    while (bus8.done !== 1'b1 && done_at < 100) begin
      if (bus8.busy === 1'b1) busy_cnt++;
      @(negedge clk);
      done_at++;
    end
    if (bus8.done !== 1'b1) done_at = -1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    checks++; if (bus8.ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 1", bus8.ready); end
    checks++; if (bus8.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", bus8.busy); end
    checks++; if (bus8.done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", bus8.done); end
    checks++; if (bus8.product !== 16'h0000) begin errors++; $display("[TB] FAIL reset_product: got %h expected 0000", bus8.product); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    int done_at, busy_cnt;
    run_op8(8'd13, 8'd11, done_at, busy_cnt);
    checks++; if (done_at !== 8) begin errors++; $display("[TB] FAIL basic_latency: got %0d expected 8", done_at); end
    checks++; if (busy_cnt !== 8) begin errors++; $display("[TB] FAIL basic_busy_cycles: got %0d expected 8", busy_cnt); end
    checks++; if (bus8.product !== 16'h008F) begin errors++; $display("[TB] FAIL basic_product: got %h expected 008f", bus8.product); end
    checks++; if (bus8.ready !== 1'b0) begin errors++; $display("[TB] FAIL basic_ready_in_done: got %b expected 0", bus8.ready); end
    @(negedge clk);
    checks++; if (bus8.ready !== 1'b1) begin errors++; $display("[TB] FAIL basic_ready_after: got %b expected 1", bus8.ready); end
    checks++; if (bus8.done !== 1'b0) begin errors++; $display("[TB] FAIL basic_done_pulse: got %b expected 0", bus8.done); end
    checks++; if (bus8.product !== 16'h008F) begin errors++; $display("[TB] FAIL basic_product_hold: got %h expected 008f", bus8.product); end
  endtask

  task automatic test_max;
    int done_at, busy_cnt;
    run_op8(8'd255, 8'd255, done_at, busy_cnt);
    checks++; if (done_at !== 8) begin errors++; $display("[TB] FAIL max_latency: got %0d expected 8", done_at); end
    checks++; if (bus8.product !== 16'hFE01) begin errors++; $display("[TB] FAIL max_product: got %h expected fe01", bus8.product); end
    @(negedge clk);
  endtask

  task automatic test_zero;
    int done_at, busy_cnt;
    run_op8(8'd0, 8'd200, done_at, busy_cnt);
    checks++; if (done_at !== 8) begin errors++; $display("[TB] FAIL zero_latency: got %0d expected 8", done_at); end
    checks++; if (busy_cnt !== 8) begin errors++; $display("[TB] FAIL zero_busy_cycles: got %0d expected 8", busy_cnt); end
    checks++; if (bus8.product !== 16'h0000) begin errors++; $display("[TB] FAIL zero_product: got %h expected 0000", bus8.product); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    bus8.a     = 8'd3;
    bus8.b     = 8'd5;
    bus8.start = 1'b1;
    for (int k = 0; k <= 18; k++) begin
      @(negedge clk);
      if (k == 0) begin
        bus8.a = 8'd7;
        bus8.b = 8'd9;
      end
      case (k)
        7: begin
          checks++; if (bus8.product !== 16'd0) begin errors++; $display("[TB] FAIL b2b_product_before: got %0d expected 0", bus8.product); end
        end
        8: begin
          checks++; if (bus8.done !== 1'b1) begin errors++; $display("[TB] FAIL b2b_done1: got %b expected 1", bus8.done); end
          checks++; if (bus8.product !== 16'd15) begin errors++; $display("[TB] FAIL b2b_product1: got %0d expected 15", bus8.product); end
        end
        9: begin
          checks++; if (bus8.ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_ready_gap: got %b expected 1", bus8.ready); end
        end
        10: begin
          checks++; if (bus8.busy !== 1'b1) begin errors++; $display("[TB] FAIL b2b_second_accept: got %b expected 1", bus8.busy); end
        end
        17: begin
          checks++; if (bus8.product !== 16'd15) begin errors++; $display("[TB] FAIL b2b_product_hold: got %0d expected 15", bus8.product); end
          checks++; if (bus8.done !== 1'b0) begin errors++; $display("[TB] FAIL b2b_done_early: got %b expected 0", bus8.done); end
        end
        18: begin
          checks++; if (bus8.done !== 1'b1) begin errors++; $display("[TB] FAIL b2b_done2: got %b expected 1", bus8.done); end
          checks++; if (bus8.product !== 16'd63) begin errors++; $display("[TB] FAIL b2b_product2: got %0d expected 63", bus8.product); end
        end
        default: ;
      endcase
    end
    bus8.start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ignore_start;
    bus8.a     = 8'd6;
    bus8.b     = 8'd7;
    bus8.start = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (k == 4) begin
        bus8.a     = 8'd255;
        bus8.b     = 8'd255;
        bus8.start = 1'b1;
      end else begin
        bus8.start = 1'b0;
      end
      case (k)
        7: begin
          checks++; if (bus8.done !== 1'b0) begin errors++; $display("[TB] FAIL ignore_done_early: got %b expected 0", bus8.done); end
        end
        8: begin
          checks++; if (bus8.done !== 1'b1) begin errors++; $display("[TB] FAIL ignore_done: got %b expected 1", bus8.done); end
          checks++; if (bus8.product !== 16'd42) begin errors++; $display("[TB] FAIL ignore_product: got %0d expected 42", bus8.product); end
        end
        9: begin
          checks++; if (bus8.ready !== 1'b1) begin errors++; $display("[TB] FAIL ignore_ready: got %b expected 1", bus8.ready); end
        end
        default: ;
      endcase
    end
  endtask

  task automatic test_async_reset;
    int done_at, busy_cnt, done_seen;
    run_op8(8'd13, 8'd11, done_at, busy_cnt);
    checks++; if (bus8.product !== 16'd143) begin errors++; $display("[TB] FAIL areset_prior_product: got %0d expected 143", bus8.product); end
    @(negedge clk);
    bus8.a     = 8'd13;
    bus8.b     = 8'd11;
    bus8.start = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    repeat (5) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++; if (bus8.product !== 16'd0) begin errors++; $display("[TB] FAIL areset_product: got %0d expected 0", bus8.product); end
    checks++; if (bus8.ready !== 1'b1) begin errors++; $display("[TB] FAIL areset_ready: got %b expected 1", bus8.ready); end
    checks++; if (bus8.busy !== 1'b0) begin errors++; $display("[TB] FAIL areset_busy: got %b expected 0", bus8.busy); end
    checks++; if (bus8.done !== 1'b0) begin errors++; $display("[TB] FAIL areset_done: got %b expected 0", bus8.done); end
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus8.done === 1'b1 || bus8.busy === 1'b1) done_seen++;
    end
    checks++; if (done_seen !== 0) begin errors++; $display("[TB] FAIL areset_discard: got %0d active cycles expected 0", done_seen); end
  endtask

  task automatic test_width32;
    int done_at;
    bus32.a     = 32'hFFFF_FFFF;
    bus32.b     = 32'hFFFF_FFFF;
    bus32.start = 1'b1;
    @(negedge clk);
    bus32.start = 1'b0;
    bus32.a     = 32'h0;
    bus32.b     = 32'h0;
    done_at     = 0;
    while (bus32.done !== 1'b1 && done_at < 200) begin
      @(negedge clk);
      done_at++;
    end
    if (bus32.done !== 1'b1) done_at = -1;
    checks++; if (done_at !== 32) begin errors++; $display("[TB] FAIL w32_latency: got %0d expected 32", done_at); end
    checks++; if (bus32.product !== 64'hFFFF_FFFE_0000_0001) begin errors++; $display("[TB] FAIL w32_product: got %h expected fffffffe00000001", bus32.product); end
    @(negedge clk);
    checks++; if (bus32.ready !== 1'b1) begin errors++; $display("[TB] FAIL w32_ready_after: got %b expected 1", bus32.ready); end
  endtask

  initial begin
    errors      = 0;
    checks      = 0;
    bus8.start  = 1'b0;
    bus8.a      = '0;
    bus8.b      = '0;
    bus32.start = 1'b0;
    bus32.a     = '0;
    bus32.b     = '0;
    test_reset();
    test_basic();
    test_max();
    test_zero();
    test_back_to_back();
    test_ignore_start();
    test_async_reset();
    test_width32();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
